uart_fifo: RTL and testbench
============================

UART_FIFO -- requirements
Module: uart_fifo

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, depth of each of the TX and RX FIFOs; power of two, at least 2.
REQ-002 SHALL have parameter DIV_DEFAULT, default 16'd433, reset value of the baud divisor; bit time = DIV+1 sys_clk cycles.
REQ-003 SHALL have parameter BASE_ADDR, default 32'h40000018, address of the TXD register; RXD = +4, CON = +8, DIV = +C.
REQ-004 SHALL have port sys_clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-005 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port rd, input, 1 bit: bus read strobe.
REQ-007 SHALL have port wr, input, 1 bit: bus write strobe; when rd and wr are both high, wr wins.
REQ-008 SHALL have port addr, input, 32 bits: bus byte address; exact match only.
REQ-009 SHALL have port wdata, input, 32 bits: write data.
REQ-010 SHALL have port rdata, output, 32 bits: combinational read data; 0 when rd=0 or the address is unmapped.
REQ-011 SHALL have port uart_rx, input, 1 bit: serial in, asynchronous, idle high.
REQ-012 SHALL have port uart_tx, output, 1 bit: serial out, registered, idle high.
REQ-013 SHALL have port irq, output, 1 bit: registered level interrupt.

Function
REQ-014 CON bits SHALL be defined as follows:
- [0] tx_en: RW.
- [1] rx_en: RW.
- [2] tx_busy: RO; shifter active or TX FIFO non-empty.
- [3] rx_avail: RO; RX FIFO non-empty.
- [4] tx_full: RO.
- [5] rx_overrun: W1C.
- [6] frame_err: W1C.
- [7] rx_irq_en: RW.
- [8] tx_irq_en: RW.
- [31:9]: read 0.
REQ-015 A write to TXD SHALL push wdata[7:0] into the TX FIFO if tx_en=1 and the FIFO is not full; otherwise it is dropped silently. A pop in the same cycle does not free a slot for that write.
REQ-016 A read of RXD SHALL return {24'b0, head byte} and pop the head if the RX FIFO is non-empty; when empty it returns 0 with no pop.
REQ-017 A read of TXD SHALL return {24'b0, last byte pushed}.
REQ-018 A write to DIV SHALL load wdata[15:0], clamped to a minimum of 3; a read returns {16'b0, DIV}. The new value applies from the next bit boundary.
REQ-019 The TX FSM SHALL use states IDLE, START, DATA, STOP.
- IDLE: on the first edge where the TX FIFO is non-empty and tx_en=1, pop the FIFO, drive uart_tx=0, and go to START.
- Each state lasts DIV+1 cycles.
- DATA sends 8 bits, LSB first.
- STOP drives 1, then returns to IDLE, so back-to-back frames have no idle gap.
REQ-020 Clearing tx_en mid-frame SHALL let the current frame complete; no further pops occur.
REQ-021 uart_rx SHALL pass through a 2-flop synchroniser.
REQ-022 The RX FSM SHALL use states IDLE, START, DATA, STOP.
- IDLE: on a synchronised falling edge with rx_en=1, go to START.
- START: sample at (DIV+1)/2 cycles; if high, return to IDLE (glitch).
- DATA: sample 8 bits at DIV+1 intervals.
- STOP: sample the stop bit.
REQ-023 On the stop sample:
- If the stop bit is 0, set frame_err and discard the byte.
- Else, if the RX FIFO is full and not popped in the same cycle, set rx_overrun and discard the byte.
- Else, push the byte.
REQ-024 Clearing rx_en SHALL abort any frame in progress immediately, without a push, and hold the RX FSM in IDLE.
REQ-025 FIFOs SHALL use wrap-around pointers and a count of width $clog2(FIFO_DEPTH)+1. A simultaneous push and pop on a non-empty, non-full FIFO leaves count unchanged.
REQ-026 irq SHALL be registered as (rx_irq_en & (rx_avail | rx_overrun | frame_err)) | (tx_irq_en & ~tx_busy).

Reset
REQ-027 While reset=0, the block SHALL hold:
- uart_tx=1 and irq=0;
- both FSMs in IDLE and both FIFOs empty;
- CON=32'h00000003 and DIV=DIV_DEFAULT;
- TXD shadow = 0 and synchroniser flops = 1.
REQ-028 Reset asserted mid-frame SHALL force uart_tx high asynchronously; no partial frame resumes after release.

Verification
REQ-029 DIV=3, write 8'hA5 to TXD -> uart_tx low from the next edge, bits 1,0,1,0,0,1,0,1 each 4 cycles, then stop high; frame is 40 cycles; tx_busy clears after it.
REQ-030 FIFO_DEPTH=4, DIV=3, five TXD writes with no gaps -> first four frames sent back-to-back (160 cycles, no idle gap); fifth write dropped while tx_full=1.
REQ-031 Drive frames 8'h3C and 8'hC3 at DIV=7 -> rx_avail=1; RXD reads return 32'h3C, then 32'hC3, then 0.
REQ-032 Fill the RX FIFO with 4 bytes, send a 5th -> rx_overrun=1, FIFO content unchanged; write 32'h20 to CON -> rx_overrun=0, tx_en and rx_en unchanged.
REQ-033 Frame with stop bit 0 -> frame_err=1, no push. A 2-cycle low glitch at DIV=7 -> nothing received, no flags set.
REQ-034 Assert reset mid-TX-frame -> uart_tx=1 asynchronously, CON reads 32'h3, DIV reads DIV_DEFAULT, irq=0.

Source files
------------

// File: rtl/uart_fifo.sv
`default_nettype none
// ============================================================================
// Module   : uart_fifo
// Brief    : Memory-mapped UART with TX/RX byte FIFOs, baud divisor and IRQ.
// Revision : 1.0
// ============================================================================
module uart_fifo #(
    parameter int unsigned FIFO_DEPTH  = 4,
    parameter logic [15:0] DIV_DEFAULT = 16'd433,
    parameter logic [31:0] BASE_ADDR   = 32'h40000018
) (
    input  logic        sys_clk,
    input  logic        reset,
    input  logic        rd,
    input  logic        wr,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    input  logic        uart_rx,
    output logic        uart_tx,
    output logic        irq
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_DATA  = 2'd2;
    localparam logic [1:0] S_STOP  = 2'd3;

    logic sel_txd, sel_rxd, sel_con, sel_div, rd_act, wr_act;
    assign sel_txd = (addr == BASE_ADDR);
    assign sel_rxd = (addr == BASE_ADDR + 32'h4);
    assign sel_con = (addr == BASE_ADDR + 32'h8);
    assign sel_div = (addr == BASE_ADDR + 32'hC);
    assign wr_act  = wr;
    assign rd_act  = rd & ~wr;

    logic        tx_en, rx_en, rx_irq_en, tx_irq_en, rx_overrun, frame_err;
    logic [15:0] div;
    logic [7:0]  txd_shadow;
    logic        unused_wdata;
    assign unused_wdata = ^wdata[31:16];

    // TX FIFO
    logic [7:0]    tx_mem [FIFO_DEPTH];
    logic [AW-1:0] tx_wp, tx_rp;
    logic [CW-1:0] tx_cnt;
    logic          tx_full, tx_empty, tx_push, tx_pop;
    logic [1:0]    tx_state;
    logic [15:0]   tx_tmr, tx_lim;
    logic [7:0]    tx_shift;
    logic [2:0]    tx_bit;
    logic          tx_tick, tx_busy;

    assign tx_full  = (tx_cnt == FULL_CNT);
    assign tx_empty = (tx_cnt == '0);
    assign tx_push  = wr_act & sel_txd & tx_en & ~tx_full;
    assign tx_tick  = (tx_tmr == tx_lim);
    assign tx_pop   = tx_en & ~tx_empty &
                      ((tx_state == S_IDLE) | ((tx_state == S_STOP) & tx_tick));
    assign tx_busy  = (tx_state != S_IDLE) | ~tx_empty;

    always_ff @(posedge sys_clk) begin
        if (tx_push) tx_mem[tx_wp] <= wdata[7:0];
    end

    always_ff @(posedge sys_clk or negedge reset) begin
        if (!reset) begin
            tx_wp  <= '0;
            tx_rp  <= '0;
            tx_cnt <= '0;
        end else begin
            if (tx_push) tx_wp <= tx_wp + AW'(1);
            if (tx_pop)  tx_rp <= tx_rp + AW'(1);
            case ({tx_push, tx_pop})
                2'b10:   tx_cnt <= tx_cnt + CW'(1);
                2'b01:   tx_cnt <= tx_cnt - CW'(1);
                default: ;
            endcase
        end
    end

    // Popping straight out of STOP keeps consecutive frames gap-free.
    always_ff @(posedge sys_clk or negedge reset) begin
        if (!reset) begin
            tx_state <= S_IDLE;
            uart_tx  <= 1'b1;
            tx_tmr   <= '0;
            tx_lim   <= DIV_DEFAULT;
            tx_shift <= '0;
            tx_bit   <= '0;
        end else begin
            case (tx_state)
                S_IDLE: if (tx_pop) begin
                    tx_state <= S_START;
                    uart_tx  <= 1'b0;
                    tx_shift <= tx_mem[tx_rp];
                    tx_tmr   <= '0;
                    tx_lim   <= div;
                end
                S_START: if (tx_tick) begin
                    tx_state <= S_DATA;
                    uart_tx  <= tx_shift[0];
                    tx_shift <= tx_shift >> 1;
                    tx_bit   <= '0;
                    tx_tmr   <= '0;
                    tx_lim   <= div;
                end else tx_tmr <= tx_tmr + 16'd1;
                S_DATA: if (tx_tick) begin
                    tx_tmr <= '0;
                    tx_lim <= div;
                    if (tx_bit == 3'd7) begin
                        tx_state <= S_STOP;
                        uart_tx  <= 1'b1;
                    end else begin
                        uart_tx  <= tx_shift[0];
                        tx_shift <= tx_shift >> 1;
                        tx_bit   <= tx_bit + 3'd1;
                    end
                end else tx_tmr <= tx_tmr + 16'd1;
                default: if (tx_tick) begin
                    tx_tmr <= '0;
                    tx_lim <= div;
                    if (tx_pop) begin
                        tx_state <= S_START;
                        uart_tx  <= 1'b0;
                        tx_shift <= tx_mem[tx_rp];
                    end else tx_state <= S_IDLE;
                end else tx_tmr <= tx_tmr + 16'd1;
            endcase
        end
    end

    // RX synchroniser, FSM and FIFO
    logic [1:0]    rx_sync;
    logic          rx_s, rx_prev, rx_fall;
    logic [1:0]    rx_state;
    logic [15:0]   rx_tmr, rx_lim;
    logic [7:0]    rx_shift;
    logic [2:0]    rx_bit;
    logic [7:0]    rx_mem [FIFO_DEPTH];
    logic [AW-1:0] rx_wp, rx_rp;
    logic [CW-1:0] rx_cnt;
    logic          rx_full, rx_empty, rx_push, rx_pop, stop_smp, ovr_set, ferr_set;

    assign rx_s     = rx_sync[1];
    assign rx_fall  = rx_prev & ~rx_s;
    assign rx_full  = (rx_cnt == FULL_CNT);
    assign rx_empty = (rx_cnt == '0);
    assign rx_pop   = rd_act & sel_rxd & ~rx_empty;
    assign stop_smp = rx_en & (rx_state == S_STOP) & (rx_tmr == rx_lim);
    assign ferr_set = stop_smp & ~rx_s;
    assign ovr_set  = stop_smp & rx_s & rx_full & ~rx_pop;
    assign rx_push  = stop_smp & rx_s & (~rx_full | rx_pop);

    always_ff @(posedge sys_clk or negedge reset) begin
        if (!reset) begin
            rx_sync <= 2'b11;
            rx_prev <= 1'b1;
        end else begin
            rx_sync <= {rx_sync[0], uart_rx};
            rx_prev <= rx_s;
        end
    end

    always_ff @(posedge sys_clk or negedge reset) begin
        if (!reset) begin
            rx_state <= S_IDLE;
            rx_tmr   <= '0;
            rx_lim   <= DIV_DEFAULT;
            rx_shift <= '0;
            rx_bit   <= '0;
        end else if (!rx_en) begin
            rx_state <= S_IDLE;
        end else begin
            case (rx_state)
                S_IDLE: if (rx_fall) begin
                    rx_state <= S_START;
                    rx_tmr   <= '0;
                    rx_lim   <= div;
                end
                S_START: if (rx_tmr == (rx_lim >> 1)) begin
                    rx_state <= rx_s ? S_IDLE : S_DATA;
                    rx_tmr   <= '0;
                    rx_bit   <= '0;
                    rx_lim   <= div;
                end else rx_tmr <= rx_tmr + 16'd1;
                S_DATA: if (rx_tmr == rx_lim) begin
                    rx_shift <= {rx_s, rx_shift[7:1]};
                    rx_tmr   <= '0;
                    rx_lim   <= div;
                    rx_bit   <= rx_bit + 3'd1;
                    if (rx_bit == 3'd7) rx_state <= S_STOP;
                end else rx_tmr <= rx_tmr + 16'd1;
                default: if (rx_tmr == rx_lim) rx_state <= S_IDLE;
                         else rx_tmr <= rx_tmr + 16'd1;
            endcase
        end
    end

    always_ff @(posedge sys_clk) begin
        if (rx_push) rx_mem[rx_wp] <= rx_shift;
    end

    always_ff @(posedge sys_clk or negedge reset) begin
        if (!reset) begin
            rx_wp  <= '0;
            rx_rp  <= '0;
            rx_cnt <= '0;
        end else begin
            if (rx_push) rx_wp <= rx_wp + AW'(1);
            if (rx_pop)  rx_rp <= rx_rp + AW'(1);
            case ({rx_push, rx_pop})
                2'b10:   rx_cnt <= rx_cnt + CW'(1);
                2'b01:   rx_cnt <= rx_cnt - CW'(1);
                default: ;
            endcase
        end
    end

    // A CON write carrying any W1C bit only clears flags and leaves the RW fields alone.
    always_ff @(posedge sys_clk or negedge reset) begin
        if (!reset) begin
            tx_en      <= 1'b1;
            rx_en      <= 1'b1;
            rx_irq_en  <= 1'b0;
            tx_irq_en  <= 1'b0;
            rx_overrun <= 1'b0;
            frame_err  <= 1'b0;
            div        <= DIV_DEFAULT;
            txd_shadow <= '0;
            irq        <= 1'b0;
        end else begin
            if (wr_act && sel_con) begin
                if (wdata[6:5] != 2'b00) begin
                    if (wdata[5]) rx_overrun <= 1'b0;
                    if (wdata[6]) frame_err  <= 1'b0;
                end else begin
                    tx_en     <= wdata[0];
                    rx_en     <= wdata[1];
                    rx_irq_en <= wdata[7];
                    tx_irq_en <= wdata[8];
                end
            end
            if (ovr_set)  rx_overrun <= 1'b1;
            if (ferr_set) frame_err  <= 1'b1;
            if (wr_act && sel_div) div <= (wdata[15:0] < 16'd3) ? 16'd3 : wdata[15:0];
            if (tx_push) txd_shadow <= wdata[7:0];
            irq <= (rx_irq_en & (~rx_empty | rx_overrun | frame_err)) | (tx_irq_en & ~tx_busy);
        end
    end

    always_comb begin
        rdata = '0;
        if (rd_act) begin
            if (sel_txd)      rdata = {24'h0, txd_shadow};
            else if (sel_rxd) rdata = rx_empty ? 32'h0 : {24'h0, rx_mem[rx_rp]};
            else if (sel_con) rdata = {23'h0, tx_irq_en, rx_irq_en, frame_err, rx_overrun,
                                       tx_full, ~rx_empty, tx_busy, rx_en, tx_en};
            else if (sel_div) rdata = {16'h0, div};
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_uart_fifo.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_fifo
// Brief    : Self-checking bench for uart_fifo against a queue-based model.
// Revision : 1.0
// ============================================================================
module tb_uart_fifo;
    localparam logic [31:0] BASE    = 32'h40000018;
    localparam logic [31:0] A_TXD   = BASE;
    localparam logic [31:0] A_RXD   = BASE + 32'h4;
    localparam logic [31:0] A_CON   = BASE + 32'h8;
    localparam logic [31:0] A_DIV   = BASE + 32'hC;
    localparam logic [15:0] DIV_DEF = 16'd433;
    localparam int          DEPTH   = 4;

    logic        sys_clk = 1'b0;
    logic        reset   = 1'b0;
    logic        rd      = 1'b0;
    logic        wr      = 1'b0;
    logic        uart_rx = 1'b1;
    logic [31:0] addr    = '0;
    logic [31:0] wdata   = '0;
    logic [31:0] rdata;
    logic        uart_tx, irq;

    int   checks = 0;
    int   errors = 0;
    int   rx_div = 7;
    logic exp_q[$];
    logic got_q[$];

    uart_fifo #(.FIFO_DEPTH(DEPTH), .DIV_DEFAULT(DIV_DEF), .BASE_ADDR(BASE)) dut (
        .sys_clk(sys_clk), .reset(reset), .rd(rd), .wr(wr), .addr(addr),
        .wdata(wdata), .rdata(rdata), .uart_rx(uart_rx), .uart_tx(uart_tx), .irq(irq)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] con_word(input logic txe, rxe, busy, avail, full,
                                             ovr, ferr, rie, tie);
        return {23'h0, tie, rie, ferr, ovr, full, avail, busy, rxe, txe};
    endfunction

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
        wr = 1'b1; addr = a; wdata = d;
        @(negedge sys_clk);
        wr = 1'b0;
    endtask

    task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
        rd = 1'b1; addr = a;
        #1 d = rdata;
        @(negedge sys_clk);
        rd = 1'b0;
    endtask

    // Serial line expectation: start, 8 data bits LSB first, stop; each bit_len samples.
    task automatic add_frame(input logic [7:0] b, input int bit_len);
        logic [9:0] f;
        f = {1'b1, b, 1'b0};
        for (int i = 0; i < 10; i++)
            for (int k = 0; k < bit_len; k++) exp_q.push_back(f[i]);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop);
        logic [9:0] f;
        f = {stop, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            uart_rx = f[i];
            repeat (rx_div + 1) @(negedge sys_clk);
        end
        uart_rx = 1'b1;
        repeat (2) @(negedge sys_clk);
    endtask

    initial begin
        logic [31:0] r;
        logic [7:0]  wb [5];
        logic [7:0]  rxq[$];
        logic [7:0]  b;
        logic        ovr_exp;
        int          mism;

        repeat (3) @(negedge sys_clk);
        check("rst_uart_tx", {31'h0, uart_tx}, 32'h1);
        check("rst_irq", {31'h0, irq}, 32'h0);
        reset = 1'b1;
        @(negedge sys_clk);
        bus_read(A_CON, r); check("rst_con", r, 32'h3);
        bus_read(A_DIV, r); check("rst_div", r, {16'h0, DIV_DEF});
        bus_read(A_TXD, r); check("rst_txd", r, 32'h0);
        bus_read(A_RXD, r); check("rst_rxd_empty", r, 32'h0);
        bus_read(BASE + 32'h10, r); check("unmapped_read", r, 32'h0);
        addr = A_CON; #1 check("rdata_no_rd", rdata, 32'h0);

        bus_write(A_DIV, 32'h0005_0001);
        bus_read(A_DIV, r); check("div_clamp", r, 32'h3);

        // TX: one frame, then a burst of five while the shifter is busy
        for (int i = 0; i < 5; i++) wb[i] = 8'($urandom);
        wb[4] = wb[3] ^ 8'h5A;
        exp_q = {};
        add_frame(8'hA5, 4);
        for (int i = 0; i < 4; i++) add_frame(wb[i], 4);
        for (int i = 0; i < 10; i++) exp_q.push_back(1'b1);
        got_q = {};
        bus_write(A_TXD, 32'hA5);
        fork
            for (int i = 0; i < 210; i++) begin
                @(negedge sys_clk);
                got_q.push_back(uart_tx);
            end
            begin
                repeat (3) @(negedge sys_clk);
                for (int j = 0; j < 5; j++) bus_write(A_TXD, {24'h0, wb[j]});
                bus_read(A_CON, r);
                check("tx_full_con", r, con_word(1, 1, 1, 0, 1, 0, 0, 0, 0));
                bus_read(A_TXD, r);
                check("txd_last_pushed", r, {24'h0, wb[3]});
            end
        join
        mism = 0;
        for (int i = 0; i < 40; i++) if (got_q[i] !== exp_q[i]) mism++;
        check("tx_frame_a5", 32'(mism), 32'h0);
        mism = 0;
        for (int i = 0; i < 210; i++) if (got_q[i] !== exp_q[i]) mism++;
        check("tx_stream_b2b", 32'(mism), 32'h0);
        bus_read(A_CON, r); check("tx_idle_con", r, 32'h3);

        bus_write(A_CON, 32'h103);
        repeat (2) @(negedge sys_clk);
        check("tx_irq", {31'h0, irq}, 32'h1);
        bus_write(A_CON, 32'h3);
        repeat (2) @(negedge sys_clk);
        check("irq_off", {31'h0, irq}, 32'h0);

        // RX basic
        bus_write(A_DIV, 32'h7);
        send_frame(8'h3C, 1'b1);
        send_frame(8'hC3, 1'b1);
        bus_read(A_CON, r); check("rx_avail_con", r, con_word(1, 1, 0, 1, 0, 0, 0, 0, 0));
        bus_write(A_CON, 32'h83);
        repeat (2) @(negedge sys_clk);
        check("rx_irq", {31'h0, irq}, 32'h1);
        bus_read(A_RXD, r); check("rxd_first", r, 32'h3C);
        bus_read(A_RXD, r); check("rxd_second", r, 32'hC3);
        bus_read(A_RXD, r); check("rxd_empty", r, 32'h0);
        repeat (2) @(negedge sys_clk);
        check("rx_irq_clear", {31'h0, irq}, 32'h0);
        bus_write(A_CON, 32'h3);

        // RX overrun with random bytes
        rxq = {};
        ovr_exp = 1'b0;
        for (int i = 0; i < 5; i++) begin
            b = 8'($urandom);
            send_frame(b, 1'b1);
            if (rxq.size() < DEPTH) rxq.push_back(b);
            else ovr_exp = 1'b1;
        end
        bus_read(A_CON, r); check("rx_overrun_con", r, con_word(1, 1, 0, 1, 0, ovr_exp, 0, 0, 0));
        while (rxq.size() > 0) begin
            bus_read(A_RXD, r);
            check("rx_fifo_data", r, {24'h0, rxq.pop_front()});
        end
        bus_read(A_RXD, r); check("rx_fifth_dropped", r, 32'h0);
        bus_write(A_CON, 32'h20);
        bus_read(A_CON, r); check("w1c_overrun", r, 32'h3);

        // Framing error and glitch rejection
        send_frame(8'($urandom), 1'b0);
        bus_read(A_CON, r); check("frame_err_con", r, con_word(1, 1, 0, 0, 0, 0, 1, 0, 0));
        bus_read(A_RXD, r); check("frame_err_nopush", r, 32'h0);
        bus_write(A_CON, 32'h40);
        bus_read(A_CON, r); check("w1c_frame_err", r, 32'h3);
        uart_rx = 1'b0;
        repeat (2) @(negedge sys_clk);
        uart_rx = 1'b1;
        repeat (40) @(negedge sys_clk);
        bus_read(A_CON, r); check("glitch_con", r, 32'h3);

        // rx_en cleared mid-frame aborts it
        fork
            send_frame(8'hFF, 1'b1);
            begin
                repeat (30) @(negedge sys_clk);
                bus_write(A_CON, 32'h1);
                bus_write(A_CON, 32'h3);
            end
        join
        repeat (4) @(negedge sys_clk);
        bus_read(A_CON, r); check("rx_abort_con", r, 32'h3);

        // Reset in the middle of a TX frame
        send_frame(8'($urandom), 1'b1);
        bus_write(A_CON, 32'h83);
        repeat (2) @(negedge sys_clk);
        check("irq_pre_reset", {31'h0, irq}, 32'h1);
        bus_write(A_TXD, 32'h00);
        repeat (12) @(negedge sys_clk);
        check("tx_mid_frame_low", {31'h0, uart_tx}, 32'h0);
        #2 reset = 1'b0;
        #1;
        check("rst_async_tx", {31'h0, uart_tx}, 32'h1);
        check("rst_async_irq", {31'h0, irq}, 32'h0);
        @(negedge sys_clk);
        reset = 1'b1;
        @(negedge sys_clk);
        bus_read(A_CON, r); check("post_rst_con", r, 32'h3);
        bus_read(A_DIV, r); check("post_rst_div", r, {16'h0, DIV_DEF});
        mism = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge sys_clk);
            if (uart_tx !== 1'b1) mism++;
        end
        check("no_frame_resume", 32'(mism), 32'h0);
        check("post_rst_irq", {31'h0, irq}, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
